// File: rtl/mem_pkg.sv
// Shared definitions for the memory controller / responder pair.
package mem_pkg;

    // Default word and address widths, shared with the controller.
    localparam int MEM_DATA_W = 8;
    localparam int MEM_ADDR_W = 4;

    // Responder state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mem_state_t;

    // Latched operation.
    typedef enum logic {
        OP_WR = 1'b0,
        OP_RD = 1'b1
    } mem_op_t;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write, synchronous registered read.
// Storage has no reset; only the read output register is cleared.
module mem_word_array
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = MEM_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: contents are undefined until first written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read output register: loads only on a read, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_array_responder.sv
// Memory-side responder for the four-phase request/done handshake.
// Accepts one level request, waits WAIT_CYCLES, performs a single array
// access and holds mem_done until the request is withdrawn.
module mem_array_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = MEM_DATA_W,
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_write,
    input  logic              mem_read,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              mem_err
);

    // $clog2(1) is 0, so a zero wait count still needs a 1-bit counter.
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    mem_state_t        state;
    mem_op_t           op;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic req_held;
    logic accept;
    logic access;
    logic arr_we;
    logic arr_re;

    // Request level of the latched op; the other request is ignored once busy.
    always_comb begin
        req_held = (op == OP_WR) ? mem_write : mem_read;
        accept   = (state == IDLE) && (mem_write ^ mem_read);
        access   = (state == BUSY) && req_held && (cnt == '0);
        arr_we   = access && (op == OP_WR);
        arr_re   = access && (op == OP_RD);
    end

    // Address/data capture at acceptance; later changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
        end
    end

    // Handshake FSM with registered mem_done / mem_err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op       <= OP_WR;
            cnt      <= '0;
            mem_done <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            mem_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_write && mem_read) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else if (accept) begin
                        op    <= mem_write ? OP_WR : OP_RD;
                        cnt   <= CNT_W'(WAIT_CYCLES);
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!req_held) begin
                        // Abort: no access, single-cycle error pulse.
                        mem_err <= 1'b1;
                        state   <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        mem_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (!req_held) begin
                        mem_done <= 1'b0;
                        state    <= IDLE;
                    end
                end
                ERR: begin
                    if (!mem_write && !mem_read) begin
                        state <= IDLE;
                    end else begin
                        mem_err <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    mem_done <= 1'b0;
                end
            endcase
        end
    end

    mem_word_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .addr  (addr_q),
        .we    (arr_we),
        .wdata (wdata_q),
        .re    (arr_re),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_array_responder.sv
// Self-checking bench for mem_array_responder.
module tb_mem_array_responder;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 4;
    localparam int WAIT    = 2;
    // Request set before edge k; mem_done high after edge k+WAIT+1, which is
    // the (WAIT+2)-th falling edge counted from the request.
    localparam int EXP_LAT = WAIT + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mem_write = 1'b0;
    logic              mem_read = 1'b0;
    logic [ADDR_W-1:0] mem_addr = '0;
    logic [DATA_W-1:0] mem_wdata = '0;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              mem_err;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference memory: contents plus a written flag per word.
    logic [DATA_W-1:0] ref_mem [16];
    bit                ref_vld [16];

    mem_array_responder #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .WAIT_CYCLES (WAIT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    // Raise one request at the current falling edge and wait (bounded) for
    // mem_done; returns falling edges waited (-1 on timeout) and read data.
    task automatic xact(input bit is_wr, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, output int lat,
                        output logic [DATA_W-1:0] rd);
        mem_write = is_wr;
        mem_read  = ~is_wr;
        mem_addr  = a;
        mem_wdata = d;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_done) begin
                lat = i;
                break;
            end
        end
        rd = mem_rdata;
        if (is_wr && lat > 0) begin
            ref_mem[a] = d;
            ref_vld[a] = 1'b1;
        end
    endtask

    // Withdraw requests and wait (bounded) for mem_done to fall.
    task automatic release_req(output int lat);
        mem_write = 1'b0;
        mem_read  = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!mem_done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (mem_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_done got=%b exp=0", mem_done);
        end
        tests_run++;
        if (mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_err got=%b exp=0", mem_err);
        end
        tests_run++;
        if (mem_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_rdata got=%h exp=00", mem_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_read();
        int lat;
        int fall;
        logic [DATA_W-1:0] rd;
        xact(1'b1, 4'd3, 8'hA5, lat, rd);
        tests_run++;
        if (lat !== EXP_LAT) begin
            tests_failed++;
            $display("FAIL wr_latency got=%0d exp=%0d", lat, EXP_LAT);
        end
        release_req(fall);
        tests_run++;
        if (fall !== 1) begin
            tests_failed++;
            $display("FAIL wr_done_fall got=%0d exp=1", fall);
        end
        xact(1'b0, 4'd3, 8'h00, lat, rd);
        tests_run++;
        if (lat !== EXP_LAT) begin
            tests_failed++;
            $display("FAIL rd_latency got=%0d exp=%0d", lat, EXP_LAT);
        end
        tests_run++;
        if (rd !== 8'hA5) begin
            tests_failed++;
            $display("FAIL rd_data got=%h exp=a5", rd);
        end
        mem_addr = 4'd9;
        @(negedge clk);
        tests_run++;
        if (mem_rdata !== 8'hA5 || mem_done !== 1'b1) begin
            tests_failed++;
            $display("FAIL rd_hold got=%h/%b exp=a5/1", mem_rdata, mem_done);
        end
        release_req(fall);
        tests_run++;
        if (fall !== 1) begin
            tests_failed++;
            $display("FAIL rd_done_fall got=%0d exp=1", fall);
        end
    endtask

    task automatic test_both_err();
        int lat;
        int fall;
        logic [DATA_W-1:0] rd;
        mem_write = 1'b1;
        mem_read  = 1'b1;
        mem_addr  = 4'd3;
        mem_wdata = 8'h5A;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (mem_err !== 1'b1 || mem_done !== 1'b0) begin
                tests_failed++;
                $display("FAIL err_level cyc=%0d got err=%b done=%b exp err=1 done=0",
                         i, mem_err, mem_done);
            end
        end
        mem_write = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_clear got=%b exp=0", mem_err);
        end
        xact(1'b0, 4'd3, 8'h00, lat, rd);
        tests_run++;
        if (lat !== EXP_LAT || rd !== ref_mem[3]) begin
            tests_failed++;
            $display("FAIL err_no_write got lat=%0d data=%h exp lat=%0d data=%h",
                     lat, rd, EXP_LAT, ref_mem[3]);
        end
        release_req(fall);
    endtask

    task automatic test_abort();
        int lat;
        int fall;
        logic [DATA_W-1:0] rd;
        mem_write = 1'b1;
        mem_addr  = 4'd3;
        mem_wdata = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        mem_write = 1'b0;
        @(negedge clk);
        tests_run++;
        if (mem_err !== 1'b1 || mem_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_pulse got err=%b done=%b exp err=1 done=0", mem_err, mem_done);
        end
        @(negedge clk);
        tests_run++;
        if (mem_err !== 1'b0 || mem_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_pulse_end got err=%b done=%b exp err=0 done=0",
                     mem_err, mem_done);
        end
        xact(1'b0, 4'd3, 8'h00, lat, rd);
        tests_run++;
        if (rd !== 8'hA5) begin
            tests_failed++;
            $display("FAIL abort_no_write got=%h exp=a5", rd);
        end
        release_req(fall);
    endtask

    task automatic test_back_to_back();
        int lat;
        int fall;
        logic [DATA_W-1:0] rd;
        xact(1'b1, 4'd0, 8'h11, lat, rd);
        // Request held with new address/data during DONE: nothing new starts.
        mem_addr  = 4'd15;
        mem_wdata = 8'h99;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            tests_run++;
            if (mem_done !== 1'b1) begin
                tests_failed++;
                $display("FAIL b2b_done_held got=%b exp=1", mem_done);
            end
        end
        release_req(fall);
        xact(1'b1, 4'd15, 8'hEE, lat, rd);
        tests_run++;
        if (lat !== EXP_LAT) begin
            tests_failed++;
            $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, EXP_LAT);
        end
        release_req(fall);
        xact(1'b0, 4'd0, 8'h00, lat, rd);
        tests_run++;
        if (rd !== 8'h11) begin
            tests_failed++;
            $display("FAIL b2b_rd0 got=%h exp=11", rd);
        end
        release_req(fall);
        xact(1'b0, 4'd15, 8'h00, lat, rd);
        tests_run++;
        if (rd !== 8'hEE) begin
            tests_failed++;
            $display("FAIL b2b_rd15 got=%h exp=ee", rd);
        end
        release_req(fall);
    endtask

    task automatic test_reset_midop();
        int lat;
        int fall;
        logic [DATA_W-1:0] rd;
        xact(1'b1, 4'd5, 8'h3C, lat, rd);
        release_req(fall);
        xact(1'b0, 4'd5, 8'h00, lat, rd);
        release_req(fall);
        mem_write = 1'b1;
        mem_addr  = 4'd5;
        mem_wdata = 8'h77;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (mem_done !== 1'b0 || mem_err !== 1'b0 || mem_rdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL async_reset got done=%b err=%b rdata=%h exp 0/0/00",
                     mem_done, mem_err, mem_rdata);
        end
        mem_write = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        xact(1'b0, 4'd5, 8'h00, lat, rd);
        tests_run++;
        if (rd !== 8'h3C) begin
            tests_failed++;
            $display("FAIL reset_discard_write got=%h exp=3c", rd);
        end
        release_req(fall);
    endtask

    task automatic test_random();
        int lat;
        int fall;
        logic [DATA_W-1:0] rd;
        bit is_wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int n = 0; n < 40; n++) begin
            is_wr = bit'($urandom_range(0, 1));
            a     = ADDR_W'($urandom_range(0, 15));
            d     = DATA_W'($urandom);
            xact(is_wr, a, d, lat, rd);
            tests_run++;
            if (lat !== EXP_LAT) begin
                tests_failed++;
                $display("FAIL rand_latency n=%0d got=%0d exp=%0d", n, lat, EXP_LAT);
            end
            if (!is_wr && ref_vld[a]) begin
                tests_run++;
                if (rd !== ref_mem[a]) begin
                    tests_failed++;
                    $display("FAIL rand_rdata n=%0d addr=%0d got=%h exp=%h",
                             n, a, rd, ref_mem[a]);
                end
            end
            release_req(fall);
            tests_run++;
            if (fall !== 1) begin
                tests_failed++;
                $display("FAIL rand_fall n=%0d got=%0d exp=1", n, fall);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            ref_vld[i] = 1'b0;
            ref_mem[i] = '0;
        end
        test_reset();
        test_write_read();
        test_both_err();
        test_abort();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_array_responder.md
# mem_array_responder

Memory-side responder for the controller's four-phase request/done handshake. It accepts a `mem_write` or `mem_read` level request, inserts a programmable number of wait states, performs one access on an internal word array, and raises `mem_done` until the request is withdrawn. It sits directly downstream of the controller's next-state logic and produces the `mem_done` that logic consumes.

## Interface
- `DATA_W`, default 8: data word width.
- `ADDR_W`, default 4: address width; the array holds 2**ADDR_W words.
- `WAIT_CYCLES`, default 2: wait states inserted before the access. Legal range is 0..15.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mem_write`  in  1  write request level, held high until `mem_done` is seen.
- `mem_read`  in  1  read request level, same rules.
- `mem_addr`  in  ADDR_W  access address; sampled with the request.
- `mem_wdata`  in  DATA_W  write data; sampled with the request.
- `mem_rdata`  out  DATA_W  read data; valid while `mem_done`=1 for a read.
- `mem_done`  out  1  access complete; return-to-zero.
- `mem_err`  out  1  protocol error indication.

## Operation
- Reset: state=IDLE, `mem_done`=0, `mem_err`=0, `mem_rdata`=0, wait counter=0. Array contents are not reset and are undefined until written.
- IDLE:
  - Exactly one request high: latch op, `mem_addr` and `mem_wdata`; load counter=WAIT_CYCLES; go to BUSY.
  - Both requests high: go to ERR. No access is performed.
- BUSY:
  - Counter nonzero: decrement.
  - Counter zero: perform the access. A write stores the latched data into `array[addr]`. A read loads `mem_rdata` from `array[addr]`. Then go to DONE.
  - Latched request drops before completion: abort, with no array write and `mem_rdata` unchanged. `mem_err` pulses for 1 cycle; go to IDLE.
  - The other request rising while in BUSY is ignored.
- DONE:
  - `mem_done`=1 and `mem_rdata` is held stable.
  - Latched request low: go to IDLE and drop `mem_done`.
  - Address or data changes during DONE are ignored.
- ERR: `mem_err`=1 and `mem_done`=0. Stay until both requests are low, then go to IDLE.
- A new request is accepted only from IDLE. This forces the requester to observe `mem_done`=0 before re-requesting, which completes the four phases.
- Reset asserted mid-operation forces IDLE immediately. A pending write is discarded. Outputs take their reset values asynchronously.

## Timing
- All outputs are registered with no combinational input-to-output path.
- The request is first sampled high at edge k. `mem_done` is high after edge k+WAIT_CYCLES+1. With WAIT_CYCLES=0, `mem_done` rises 1 cycle after the request.
- A write lands in the array at that same edge. `mem_rdata` updates at that same edge.
- The request is sampled low at edge m. `mem_done` is low after edge m.
- The minimum back-to-back spacing is a new request sampled at edge m+1.
- An abort pulse on `mem_err` lasts exactly one cycle. In ERR, `mem_err` is held for as long as ERR lasts.
- A read-after-write to the same address in consecutive transactions returns the newly written data.

## Structure
- Shared package `mem_pkg` holds:
  - the responder state enum: IDLE, BUSY, DONE, ERR;
  - the default `DATA_W` and `ADDR_W` constants, shared with the controller;
  - the op encoding: OP_WR, OP_RD.
- Counter width is `$clog2(WAIT_CYCLES+1)`, with a minimum of 1.
- One sub-module, `mem_word_array`:
  - synchronous write-enable storage of 2**ADDR_W by DATA_W;
  - synchronous read with an output register;
  - no reset on the storage.
- FSM, counter and latch registers live in the top module.

## Test plan
- Reset release, then write 0xA5 to address 3 with WAIT_CYCLES=2 -> `mem_done` rises 3 edges after the request; drop the request -> `mem_done` falls 1 edge later.
- Read address 3 after that write -> `mem_rdata`=0xA5 while `mem_done`=1; the value is held after `mem_addr` changes during DONE.
- Assert `mem_write` and `mem_read` together -> `mem_err`=1, `mem_done` stays 0, no array change; release both -> return to IDLE and `mem_err`=0.
- Drop `mem_write` after 1 BUSY cycle -> 1-cycle `mem_err` pulse, no `mem_done`; a later read of that address returns the prior contents.
- Back-to-back writes to addresses 0 and 15 (0x11, 0xEE), then reads of both -> 0x11 and 0xEE; the second request is accepted only after `mem_done` falls.
- Assert `rst_n` low during BUSY of a write to address 5 (previously 0x3C) -> outputs reset immediately; a read of address 5 after reset still returns 0x3C.
